control_sequencer: RTL

//  Hardwired Moore control unit that sequences the RISC datapath through fetch (T0-T2) and execute (T3-T7).

---
 rtl/control_sequencer_pkg.sv | 67 ++++++
 rtl/control_sequencer_if.sv | 30 +++
 rtl/control_sequencer_decode.sv | 35 +++
 rtl/control_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// FSM state encoding, instruction classes and the opcode -> ALU code map.
package cu_pkg;

  localparam int OPC_BITS = 5;
  localparam int ALU_BITS = 4;

  // Opcodes (top OPC_BITS of the IR)
  localparam logic [OPC_BITS-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_BITS-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_BITS-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_BITS-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_BITS-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_BITS-1:0] OPC_AND  = 5'b01001;
  localparam logic [OPC_BITS-1:0] OPC_OR   = 5'b01010;
  localparam logic [OPC_BITS-1:0] OPC_ADDI = 5'b01011;
  localparam logic [OPC_BITS-1:0] OPC_ANDI = 5'b01100;
  localparam logic [OPC_BITS-1:0] OPC_ORI  = 5'b01101;
  localparam logic [OPC_BITS-1:0] OPC_MUL  = 5'b01110;
  localparam logic [OPC_BITS-1:0] OPC_DIV  = 5'b01111;
  localparam logic [OPC_BITS-1:0] OPC_BR   = 5'b10010;
  localparam logic [OPC_BITS-1:0] OPC_JR   = 5'b10011;
  localparam logic [OPC_BITS-1:0] OPC_IN   = 5'b10101;
  localparam logic [OPC_BITS-1:0] OPC_OUT  = 5'b10110;
  localparam logic [OPC_BITS-1:0] OPC_MFHI = 5'b10111;
  localparam logic [OPC_BITS-1:0] OPC_MFLO = 5'b11000;
  localparam logic [OPC_BITS-1:0] OPC_NOP  = 5'b11001;
  localparam logic [OPC_BITS-1:0] OPC_HALT = 5'b11010;

  // ALU function select; ADD is zero so an idle alu_op reads as ADD
  localparam logic [ALU_BITS-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_BITS-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_BITS-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_BITS-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_BITS-1:0] ALU_MUL = 4'd4;
  localparam logic [ALU_BITS-1:0] ALU_DIV = 4'd5;

  // FSM state encoding
  localparam logic [3:0] ST_RST  = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_T7   = 4'd8;
  localparam logic [3:0] ST_HALT = 4'd9;

  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_LDI, CL_LD, CL_ST, CL_BR, CL_JR,
    CL_IO, CL_MV, CL_MULDIV, CL_NOP, CL_HALT
  } instr_class_t;

  // ALU function an opcode asks for; anything non-arithmetic uses ADD
  function automatic logic [ALU_BITS-1:0] alu_code(input logic [OPC_BITS-1:0] opc);
    case (opc)
      OPC_SUB:           return ALU_SUB;
      OPC_AND, OPC_ANDI: return ALU_AND;
      OPC_OR,  OPC_ORI:  return ALU_OR;
      OPC_MUL:           return ALU_MUL;
      OPC_DIV:           return ALU_DIV;
      default:           return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control-unit <-> datapath bundle. master = control unit (drives strobes),
// slave = datapath (drives IR contents and the branch-condition flop).
interface control_sequencer_if #(
  parameter int IR_W    = 32,
  parameter int ALU_OPW = 4
);
  logic [IR_W-1:0]    ir;
  logic               con_ff;
  logic               pco, pci, incpc;
  logic               iri, mari, mdri, mdro, mem_read, mem_write;
  logic               gra, grb, grc, rin, rout, baout;
  logic               ryi, rzli, rzhi, rzlo, rzho;
  logic               hii, hio, loi, loo, ipo, opi, csigno, conin;
  logic [ALU_OPW-1:0] alu_op;
  logic               run;

  modport master (
    input  ir, con_ff,
    output pco, pci, incpc, iri, mari, mdri, mdro, mem_read, mem_write,
           gra, grb, grc, rin, rout, baout, ryi, rzli, rzhi, rzlo, rzho,
           hii, hio, loi, loo, ipo, opi, csigno, conin, alu_op, run
  );

  modport slave (
    output ir, con_ff,
    input  pco, pci, incpc, iri, mari, mdri, mdro, mem_read, mem_write,
           gra, grb, grc, rin, rout, baout, ryi, rzli, rzhi, rzlo, rzho,
           hii, hio, loi, loo, ipo, opi, csigno, conin, alu_op, run
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// cu_decode: opcode -> instruction class. Macro CU_MULDIV_EN selects whether
// mul/div get their own class or fall back to nop.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] i_opc,
  output instr_class_t     o_class
);

  // Pure combinational classification; unknown opcodes behave as nop
  always_comb begin
    o_class = CL_NOP;
    case (i_opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: o_class = CL_ALU_R;
      OPC_ADDI, OPC_ANDI, OPC_ORI:       o_class = CL_ALU_I;
      OPC_LDI:                           o_class = CL_LDI;
      OPC_LD:                            o_class = CL_LD;
      OPC_ST:                            o_class = CL_ST;
      OPC_BR:                            o_class = CL_BR;
      OPC_JR:                            o_class = CL_JR;
      OPC_IN, OPC_OUT:                   o_class = CL_IO;
      OPC_MFHI, OPC_MFLO:                o_class = CL_MV;
`ifdef CU_MULDIV_EN
      OPC_MUL, OPC_DIV:                  o_class = CL_MULDIV;
`else
      OPC_MUL, OPC_DIV:                  o_class = CL_NOP;
`endif
      OPC_HALT:                          o_class = CL_HALT;
      default:                           o_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T7, HALT until clear.
// Optional mul/div sequencing is enabled by defining CU_MULDIV_EN (see cu_decode).
module control_sequencer
  import cu_pkg::*;
#(
  parameter int IR_W    = 32,
  parameter int OPC_W   = 5,
  parameter int ALU_OPW = 4
) (
  input  logic                clock,
  input  logic                clear,
  control_sequencer_if.master bus
);

  logic [3:0]       r_state;
  logic [OPC_W-1:0] r_opc;
  logic [3:0]       w_state_next;
  instr_class_t     w_class;

  cu_decode #(.OPC_W(OPC_W)) u_decode (
    .i_opc  (r_opc),
    .o_class(w_class)
  );

  // State register and opcode latch; opcode captured on the T2->T3 edge
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_RST;
      r_opc   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_T2) r_opc <= bus.ir[IR_W-1 -: OPC_W];
    end
  end

  // Next state: fetch is fixed, execute length depends on the latched class
  always_comb begin
    w_state_next = ST_RST;
    case (r_state)
      ST_RST: w_state_next = ST_T0;
      ST_T0:  w_state_next = ST_T1;
      ST_T1:  w_state_next = ST_T2;
      ST_T2:  w_state_next = ST_T3;
      ST_T3: begin
        case (w_class)
          CL_ALU_R, CL_ALU_I, CL_LDI, CL_LD, CL_ST, CL_BR, CL_MULDIV:
                   w_state_next = ST_T4;
          CL_HALT: w_state_next = ST_HALT;
          default: w_state_next = ST_T0;
        endcase
      end
      ST_T4:  w_state_next = ST_T5;
      ST_T5: begin
        case (w_class)
          CL_LD, CL_ST, CL_BR, CL_MULDIV: w_state_next = ST_T6;
          default:                        w_state_next = ST_T0;
        endcase
      end
      ST_T6:  w_state_next = (w_class == CL_LD || w_class == CL_ST) ? ST_T7 : ST_T0;
      ST_T7:  w_state_next = ST_T0;
      ST_HALT: w_state_next = ST_HALT;
      default: w_state_next = ST_RST;
    endcase
  end

  // Strobe decode from state and latched opcode only (con_ff gates br's pci)
  always_comb begin
    bus.pco = 1'b0;  bus.pci = 1'b0;  bus.incpc = 1'b0;
    bus.iri = 1'b0;  bus.mari = 1'b0; bus.mdri = 1'b0; bus.mdro = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.gra = 1'b0;  bus.grb = 1'b0;  bus.grc = 1'b0;
    bus.rin = 1'b0;  bus.rout = 1'b0; bus.baout = 1'b0;
    bus.ryi = 1'b0;  bus.rzli = 1'b0; bus.rzhi = 1'b0; bus.rzlo = 1'b0; bus.rzho = 1'b0;
    bus.hii = 1'b0;  bus.hio = 1'b0;  bus.loi = 1'b0;  bus.loo = 1'b0;
    bus.ipo = 1'b0;  bus.opi = 1'b0;  bus.csigno = 1'b0; bus.conin = 1'b0;
    bus.alu_op = '0;
    bus.run = (r_state >= ST_T0) && (r_state <= ST_T7);
    case (r_state)
      ST_T0: begin bus.pco = 1'b1; bus.mari = 1'b1; bus.incpc = 1'b1; end
      ST_T1: begin bus.mem_read = 1'b1; bus.mdri = 1'b1; end
      ST_T2: begin bus.mdro = 1'b1; bus.iri = 1'b1; end
      ST_T3: begin
        case (w_class)
          CL_ALU_R, CL_ALU_I: begin bus.grb = 1'b1; bus.rout = 1'b1; bus.ryi = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin bus.grb = 1'b1; bus.baout = 1'b1; bus.ryi = 1'b1; end
          CL_BR:     begin bus.gra = 1'b1; bus.rout = 1'b1; bus.conin = 1'b1; end
          CL_JR:     begin bus.gra = 1'b1; bus.rout = 1'b1; bus.pci = 1'b1; end
          CL_IO: begin
            bus.gra = 1'b1;
            if (r_opc == OPC_IN) begin bus.ipo = 1'b1; bus.rin = 1'b1; end
            else begin bus.rout = 1'b1; bus.opi = 1'b1; end
          end
          CL_MV: begin
            bus.gra = 1'b1; bus.rin = 1'b1;
            if (r_opc == OPC_MFHI) bus.hio = 1'b1;
            else bus.loo = 1'b1;
          end
          CL_MULDIV: begin bus.gra = 1'b1; bus.rout = 1'b1; bus.ryi = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (w_class)
          CL_ALU_R: begin
            bus.grc = 1'b1; bus.rout = 1'b1; bus.rzli = 1'b1;
            bus.alu_op = ALU_OPW'(alu_code(r_opc));
          end
          CL_ALU_I: begin
            bus.csigno = 1'b1; bus.rzli = 1'b1;
            bus.alu_op = ALU_OPW'(alu_code(r_opc));
          end
          CL_LDI, CL_LD, CL_ST: begin bus.csigno = 1'b1; bus.rzli = 1'b1; end
          CL_BR: begin bus.pco = 1'b1; bus.ryi = 1'b1; end
          CL_MULDIV: begin
            bus.grb = 1'b1; bus.rout = 1'b1; bus.rzli = 1'b1; bus.rzhi = 1'b1;
            bus.alu_op = ALU_OPW'(alu_code(r_opc));
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (w_class)
          CL_ALU_R, CL_ALU_I, CL_LDI: begin bus.rzlo = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
          CL_LD, CL_ST: begin bus.rzlo = 1'b1; bus.mari = 1'b1; end
          CL_BR:        begin bus.csigno = 1'b1; bus.rzli = 1'b1; end
          CL_MULDIV:    begin bus.rzlo = 1'b1; bus.loi = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (w_class)
          CL_LD:     begin bus.mem_read = 1'b1; bus.mdri = 1'b1; end
          CL_ST:     begin bus.gra = 1'b1; bus.rout = 1'b1; bus.mdri = 1'b1; end
          CL_BR:     begin bus.rzlo = 1'b1; bus.pci = bus.con_ff; end
          CL_MULDIV: begin bus.rzho = 1'b1; bus.hii = 1'b1; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (w_class)
          CL_LD:   begin bus.mdro = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
          CL_ST:   bus.mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
